// File: rtl/stage_bus_if.sv
// Producer/consumer bus for stage_bus_fifo: push side, pop side, occupancy and error flags.
// The FIFO connects through the slave modport; the stage logic uses master.
interface stage_bus_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic              flush;
    logic              send_en;
    logic [DATA_W-1:0] send_data;
    logic              can_send;
    logic              almost_full;
    logic              recv_en;
    logic [DATA_W-1:0] recv_data;
    logic              can_receive;
    logic [CntW-1:0]   count;
    logic              overflow_err;
    logic              underflow_err;
    logic              err_clear;

    modport master (
        output flush, send_en, send_data, recv_en, err_clear,
        input  can_send, almost_full, recv_data, can_receive, count,
               overflow_err, underflow_err
    );

    modport slave (
        input  flush, send_en, send_data, recv_en, err_clear,
        output can_send, almost_full, recv_data, can_receive, count,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/stage_bus_fifo.sv
// DEPTH-entry inter-stage packet FIFO with flush, occupancy and almost-full reporting.
// Define STAGE_BUS_ERR_CHECK_EN to enable the sticky overflow/underflow flags.
module stage_bus_fifo #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned ALMOST_FULL_LVL = DEPTH - 1
) (
    input logic        clk,
    input logic        rst_n,
    stage_bus_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // Qualified against pre-edge state: a pop never frees room for a push while full.
    assign push  = bus.send_en & ~full;
    assign pop   = bus.recv_en & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.send_data;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.can_send    = ~full;
    assign bus.can_receive = ~empty;
    assign bus.almost_full = (count_q >= CntW'(ALMOST_FULL_LVL));
    assign bus.count       = count_q;
    assign bus.recv_data   = mem_q[rd_ptr_q];

`ifdef STAGE_BUS_ERR_CHECK_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Set has priority over clear; flush does not mask the set condition.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.err_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.send_en & full) begin
            overflow_d = 1'b1;
        end
        if (bus.recv_en & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;
`else
    logic unused_err_clear;

    assign unused_err_clear  = bus.err_clear;
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif
endmodule

// File: doc/stage_bus_fifo.md
# stage_bus_fifo

Parametrised inter-stage packet bus that replaces the single-entry send/recv handshake between pipeline stages (e.g. store→fetch) with a DEPTH-entry FIFO. The producer stage pushes packets with `send_en` and the consumer stage pops them with `recv_en`. A synchronous flush supports pipeline redirects. The block keeps the single-register `can_receive` semantics as the DEPTH=1 degenerate view, and adds backpressure, occupancy reporting and illegal-operation detection.

## Interface
- `DATA_W`, 64: packet width in bits.
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ALMOST_FULL_LVL`, DEPTH-1: occupancy at or above which `almost_full` asserts; range 1..DEPTH.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all entries.
- `send_en`  in  1  push strobe from producer.
- `send_data`  in  DATA_W  packet to push.
- `can_send`  out  1  FIFO not full.
- `almost_full`  out  1  count ≥ ALMOST_FULL_LVL.
- `recv_en`  in  1  pop strobe from consumer.
- `recv_data`  out  DATA_W  head packet; valid only when `can_receive`=1.
- `can_receive`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow_err`  out  1  sticky: push attempted while full.
- `underflow_err`  out  1  sticky: pop attempted while empty.
- `err_clear`  in  1  clears both sticky flags.

## Operation
- Storage: DEPTH×DATA_W register array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- push = `send_en & can_send`; pop = `recv_en & can_receive`; both are evaluated on the state before the edge.
- push only: write `send_data` at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push and pop together: both take effect and count is unchanged. This is legal when 0<count<DEPTH.
- Full (count=DEPTH): `can_send`=0. `send_en` is dropped even if a pop occurs in the same cycle; there is no pass-through on full.
- Empty: `can_receive`=0. `recv_en` is ignored and `send_en` pushes normally. There is no same-cycle bypass.
- `flush`=1: pointers←0 and count←0. A push or pop in the same cycle is discarded. Error flags are unaffected, and a push while full in the flush cycle still sets `overflow_err`.
- Outputs `can_send`, `can_receive`, `almost_full` and `count` are derived from registered count only.
- `recv_data` = mem[rd_ptr]. Its content is don't-care while empty.

## Timing
- Reset (async assert, synchronous-release assumption on `rst_n` deassert): pointers 0, count 0, `can_send`=1, `can_receive`=0, `almost_full`=0 (or 1 if ALMOST_FULL_LVL… ≥1 so 0), flags 0, `recv_data` 0 (array cleared).
- Push-to-visible latency is 1 cycle: a packet pushed at edge N appears on `recv_data` with `can_receive`=1 after edge N.
- A pop at edge N presents the next entry after edge N.
- Sustained throughput is 1 push and 1 pop per cycle.
- `count` and the flags update on the same edge as the causing operation.
- Reset asserted mid-operation clears all state immediately. In-flight strobes are lost.

## Configuration
- `STAGE_BUS_ERR_CHECK_EN` defined:
  - `overflow_err` sets on `send_en & ~can_send`.
  - `underflow_err` sets on `recv_en & ~can_receive`.
  - Both flags are sticky until `err_clear`. If set and clear happen in the same cycle, set wins.
- Macro undefined:
  - Both flags are tied to 0 and `err_clear` is unused.
  - Illegal operations are still dropped or ignored exactly as above.

## Test plan
- Reset, then push 0xA1,0xA2,0xA3 on consecutive cycles → `count`=3, `recv_data`=0xA1; pop 3× → 0xA2, 0xA3, then `can_receive`=0.
- Fill DEPTH=4, push 0xFF while full → `can_send`=0, `overflow_err`=1, 0xFF never popped; `err_clear` → flag 0.
- With count=2, push and pop simultaneously for 10 cycles (wrap pointers twice) → `count` stays 2 and FIFO order is preserved.
- With count=4, assert `recv_en` and `send_en` together → one pop, push dropped, `count`=3, `overflow_err`=1.
- With count=3, assert `flush` together with `send_en` → `count`=0, `can_receive`=0; the next push 0x55 is popped first.
- `recv_en` while empty → `underflow_err`=1 (0 with macro undefined) and state unchanged; assert `rst_n`=0 mid-stream → all outputs at reset values within the same cycle.
